// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding, widths and defaults for hazard_ctrl.
package hazard_pkg;
  localparam int REG_W = 5;
  localparam int CNT_W = 8;
  localparam int MD_LATENCY_DEF = 32;
  typedef enum logic [1:0] {RUN = 2'd0, MD_WAIT = 2'd1, MEM_WAIT = 2'd2} state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard inputs and stall/flush controls.
interface hazard_ctrl_if;
  import hazard_pkg::*;
  logic [REG_W-1:0] Rs1D, Rs2D, RdE;
  logic MemToRegE, BranchTakenE, JalD, DmemReqM, DmemReadyM, MdStartE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MdDoneE;
  modport master (
    output Rs1D, Rs2D, RdE, MemToRegE, BranchTakenE, JalD, DmemReqM, DmemReadyM, MdStartE,
    input StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MdDoneE
  );
  modport slave (
    input Rs1D, Rs2D, RdE, MemToRegE, BranchTakenE, JalD, DmemReqM, DmemReadyM, MdStartE,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MdDoneE
  );
endinterface

// File: rtl/md_stall_counter.sv
// md_stall_counter: mul/div stall counter with load, decrement and hold.
module md_stall_counter
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] init,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= init;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush FSM; mul/div stalls built only with HAZARD_CTRL_MULDIV_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave h
);
  state_t state, state_n;
  logic mem_stall, load_use, md_active, md_load, md_done;
  if (MD_LATENCY < 1 || MD_LATENCY > 255) begin : g_bad_latency
    $error("MD_LATENCY must be 1..255");
  end
  assign mem_stall = h.DmemReqM & ~h.DmemReadyM;
  assign load_use = h.MemToRegE & (h.RdE != '0) & (h.RdE == h.Rs1D | h.RdE == h.Rs2D);
`ifdef HAZARD_CTRL_MULDIV_EN
  state_t ret;
  logic md_zero;
  always_ff @(posedge clk or posedge rst)
    if (rst) ret <= RUN;
    else if (state != MEM_WAIT) ret <= state;
  // the memory-ready cycle of a wait entered from MD_WAIT already counts as a mul/div cycle
  assign md_active = state == MD_WAIT | (state == MEM_WAIT & ret == MD_WAIT);
  assign md_load = state == RUN & ~mem_stall & h.MdStartE;
  assign md_done = md_active & ~mem_stall & md_zero;
  md_stall_counter u_cnt (
    .clk,
    .rst,
    .load(md_load),
    .dec (md_active & ~mem_stall & ~md_zero),
    .init(CNT_W'(MD_LATENCY - 1)),
    .zero(md_zero)
  );
`else
  assign md_active = 1'b0;
  assign md_load = 1'b0;
  assign md_done = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_n;
  always_comb begin
    state_n = mem_stall ? MEM_WAIT : md_load ? MD_WAIT : md_done ? RUN :
              state == MEM_WAIT ? (md_active ? MD_WAIT : RUN) : state;
  end
  always_comb begin
    {h.StallF, h.StallD, h.StallE, h.StallM, h.FlushD, h.FlushE, h.FlushM, h.FlushW, h.MdDoneE} = '0;
    if (rst) {h.FlushD, h.FlushE, h.FlushM, h.FlushW} = '1;
    else if (mem_stall) {h.StallF, h.StallD, h.StallE, h.StallM, h.FlushW} = '1;
    else if (md_done) h.MdDoneE = 1'b1;
    else if (md_active | md_load) {h.StallF, h.StallD, h.StallE, h.FlushM} = '1;
    else if (state == RUN & h.BranchTakenE) {h.FlushD, h.FlushE} = '1;
    else if (state == RUN & load_use) {h.StallF, h.StallD, h.FlushE} = '1;
    else if (state == RUN) h.FlushD = h.JalD;
  end
endmodule
